debug_unit: RTL and testbench

- Host-side controller sitting directly upstream of the mips core: it feeds the core's instruction memory and drives its clock-enable, reset and run control, and consumes the core's result/halt outputs.
- Byte commands arrive from a UART receiver. Reports go back through a UART transmitter.
- Supports program load, free run until halt, and single-step. Each run or step ends with an 8-byte report: result word, then cycle count.

---
 rtl/debug_unit.sv | 182 ++++++++++++++++++
 tb/tb_debug_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_unit.sv
// Host-side debug controller for the mips core. It takes UART command bytes, loads instruction
// memory, runs or single-steps the core, and reports the result word followed by the cycle count.
module debug_unit #(
    parameter int IMEM_ADDR_W = 8,
    parameter int CYCLE_W     = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             i_rx_data,
    input  logic                   i_rx_valid,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_start,
    input  logic                   i_tx_busy,
    output logic                   o_imem_we,
    output logic [IMEM_ADDR_W-1:0] o_imem_addr,
    output logic [31:0]            o_imem_wdata,
    output logic                   o_cpu_reset,
    output logic                   o_cpu_enable,
    input  logic [31:0]            i_cpu_result,
    input  logic                   i_cpu_halt,
    output logic [2:0]             o_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_CNT  = 3'd1,
        LOAD_WORD = 3'd2,
        RUN       = 3'd3,
        STEP      = 3'd4,
        SEND      = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        TX_REQ,
        TX_PULSE,
        TX_GAP,
        TX_WAIT
    } tx_phase_t;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;

    state_t                 state_q;
    tx_phase_t              tx_phase_q;
    logic [CYCLE_W-1:0]     cnt_q;
    logic [CYCLE_W-1:0]     cnt_d;
    logic [7:0]             words_left_q;
    logic [1:0]             byte_idx_q;
    logic [2:0]             tx_idx_q;
    logic [63:0]            report_q;
    logic [IMEM_ADDR_W-1:0] addr_q;
    logic [31:0]            wdata_q;
    logic                   we_q;
    logic                   cpu_reset_q;
    logic                   cpu_enable_q;
    logic                   tx_start_q;
    logic [7:0]             tx_data_q;

    // The cycle counter sticks at all-ones instead of wrapping.
    assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + CYCLE_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            tx_phase_q   <= TX_REQ;
            cnt_q        <= '0;
            words_left_q <= '0;
            byte_idx_q   <= '0;
            tx_idx_q     <= '0;
            report_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            cpu_reset_q  <= 1'b0;
            cpu_enable_q <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
        end else begin
            we_q        <= 1'b0;
            cpu_reset_q <= 1'b0;
            tx_start_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_rx_valid) begin
                        case (i_rx_data)
                            CMD_LOAD: state_q <= LOAD_CNT;
                            CMD_RUN, CMD_STEP: begin
                                // A core that is already halted is reported on without being enabled.
                                if (i_cpu_halt) begin
                                    state_q  <= SEND;
                                    report_q <= {i_cpu_result, 32'(cnt_q)};
                                end else begin
                                    cpu_enable_q <= 1'b1;
                                    if (i_rx_data == CMD_RUN) state_q <= RUN;
                                    else                      state_q <= STEP;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                LOAD_CNT: begin
                    if (i_rx_valid) begin
                        if (i_rx_data == 8'd0) begin
                            state_q <= IDLE;
                        end else begin
                            words_left_q <= i_rx_data;
                            addr_q       <= '0;
                            byte_idx_q   <= '0;
                            state_q      <= LOAD_WORD;
                        end
                    end
                end
                LOAD_WORD: begin
                    if (i_rx_valid) begin
                        wdata_q    <= {wdata_q[23:0], i_rx_data};
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) we_q <= 1'b1;
                    end
                    if (we_q) begin
                        addr_q       <= addr_q + IMEM_ADDR_W'(1);
                        words_left_q <= words_left_q - 8'd1;
                        if (words_left_q == 8'd1) begin
                            cpu_reset_q <= 1'b1;
                            cnt_q       <= '0;
                            state_q     <= IDLE;
                        end
                    end
                end
                RUN: begin
                    if (i_cpu_halt) begin
                        cpu_enable_q <= 1'b0;
                        report_q     <= {i_cpu_result, 32'(cnt_q)};
                        state_q      <= SEND;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                STEP: begin
                    cpu_enable_q <= 1'b0;
                    cnt_q        <= cnt_d;
                    report_q     <= {i_cpu_result, 32'(cnt_d)};
                    state_q      <= SEND;
                end
                SEND: begin
                    // Busy is not trusted until the transmitter has had a cycle to react to the pulse.
                    unique case (tx_phase_q)
                        TX_REQ: begin
                            if (!i_tx_busy) begin
                                tx_data_q  <= report_q[63:56];
                                report_q   <= {report_q[55:0], 8'h00};
                                tx_start_q <= 1'b1;
                                tx_phase_q <= TX_PULSE;
                            end
                        end
                        TX_PULSE: tx_phase_q <= TX_GAP;
                        TX_GAP:   tx_phase_q <= TX_WAIT;
                        TX_WAIT: begin
                            if (!i_tx_busy) begin
                                tx_phase_q <= TX_REQ;
                                tx_idx_q   <= tx_idx_q + 3'd1;
                                if (tx_idx_q == 3'd7) state_q <= IDLE;
                            end
                        end
                    endcase
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_state      = state_q;
    assign o_tx_data    = tx_data_q;
    assign o_tx_start   = tx_start_q;
    assign o_imem_we    = we_q;
    assign o_imem_addr  = addr_q;
    assign o_imem_wdata = wdata_q;
    assign o_cpu_reset  = cpu_reset_q;
    assign o_cpu_enable = cpu_enable_q;

endmodule

// File: tb/tb_debug_unit.sv
// Bench for debug_unit: random command traffic checked against a transaction-level model of
// memory writes, enable cycles, cycle count and the 8-byte report.
module tb_debug_unit;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rxData;
    logic          rxValid;
    logic [7:0]    txData;
    logic          txStart;
    logic          txBusy = 1'b0;
    logic          imemWe;
    logic [AW-1:0] imemAddr;
    logic [31:0]   imemWdata;
    logic          cpuReset;
    logic          cpuEnable;
    logic [31:0]   cpuResult;
    logic          cpuHalt;
    logic [2:0]    state;

    int compared = 0;
    int mismatched = 0;

    int cycleNo = 0;
    int enTotal = 0;
    int rstPulses = 0;
    int rstCycle = 0;
    int lastWrCycle = 0;
    int txViolations = 0;
    int busyLeft = 0;
    logic [AW+31:0] wrQ[$];
    logic [7:0]     txQ[$];

    int  busyLen;
    bit  haltForce;
    bit  autoHalt;
    int  haltAfter;
    int  enAtArm;
    longint modelCnt;
    logic [31:0] loadWords[8];

    debug_unit #(.IMEM_ADDR_W(AW), .CYCLE_W(32)) dut (
        .clk(clk), .reset(reset),
        .i_rx_data(rxData), .i_rx_valid(rxValid),
        .o_tx_data(txData), .o_tx_start(txStart), .i_tx_busy(txBusy),
        .o_imem_we(imemWe), .o_imem_addr(imemAddr), .o_imem_wdata(imemWdata),
        .o_cpu_reset(cpuReset), .o_cpu_enable(cpuEnable),
        .i_cpu_result(cpuResult), .i_cpu_halt(cpuHalt), .o_state(state)
    );

    always #5 clk = ~clk;

    // Core model: halts once it has been enabled for more than haltAfter cycles.
    assign cpuHalt = haltForce || (autoHalt && ((enTotal - enAtArm) > haltAfter));

    // Observe the DUT mid-cycle and play the transmitter, holding busy for busyLen cycles per byte.
    always @(negedge clk) begin
        cycleNo++;
        if (imemWe) begin
            wrQ.push_back({imemAddr, imemWdata});
            lastWrCycle = cycleNo;
        end
        if (cpuReset) begin
            rstPulses++;
            rstCycle = cycleNo;
        end
        if (cpuEnable) enTotal++;
        if (busyLeft > 0) begin
            busyLeft--;
            if (busyLeft == 0) txBusy = 1'b0;
        end
        if (txStart) begin
            if (txBusy) txViolations++;
            txQ.push_back(txData);
            if (busyLen > 0) begin
                busyLeft = busyLen;
                txBusy = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(posedge clk); #1;
        rxData = b;
        rxValid = 1'b1;
        @(posedge clk); #1;
        rxValid = 1'b0;
        rxData = 8'($urandom);
        repeat (2) @(posedge clk);
    endtask

    task automatic doLoad(input int n);
        int wm;
        int rp;
        wm = wrQ.size();
        rp = rstPulses;
        applyStimulus(8'h4C);
        applyStimulus(8'(n));
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 4; b++)
                applyStimulus(loadWords[i][31-8*b -: 8]);
        repeat (4) @(posedge clk); #1;
        checkOutput("loadWrites", 64'(wrQ.size() - wm), 64'(n));
        for (int i = 0; i < n; i++)
            if (wm + i < wrQ.size())
                checkOutput($sformatf("loadWr%0d", i), 64'(wrQ[wm+i]), 64'({8'(i), loadWords[i]}));
        checkOutput("loadCpuRst", 64'(rstPulses - rp), (n > 0) ? 64'd1 : 64'd0);
        if (n > 0) checkOutput("rstAfterWr", 64'(rstCycle - lastWrCycle), 64'd1);
        checkOutput("loadState", 64'(state), 64'd0);
        if (n > 0) modelCnt = 0;
    endtask

    task automatic doCmd(input logic [7:0] cmd, input bit hf, input bit ah, input int h,
                         input logic [31:0] res, input bit injectL);
        int tm;
        int en0;
        int expEn;
        bit done;
        logic [63:0] got;
        cpuResult = res;
        haltForce = hf;
        autoHalt = ah;
        haltAfter = h;
        enAtArm = enTotal;
        tm = txQ.size();
        en0 = enTotal;
        if (hf) begin
            expEn = 0;
        end else if (cmd == 8'h53) begin
            expEn = 1;
            modelCnt = (modelCnt + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : modelCnt + 1;
        end else begin
            expEn = h + 1;
            modelCnt = (modelCnt + h > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : modelCnt + h;
        end
        applyStimulus(cmd);
        if (injectL) begin
            repeat (3) @(posedge clk);
            applyStimulus(8'h4C);
            #1;
            checkOutput("sendIgnoresRx", 64'(state), 64'd5);
        end
        done = 1'b0;
        for (int c = 0; c < 4000 && !done; c++) begin
            @(negedge clk);
            if ((txQ.size() - tm) >= 8 && state == 3'd0) done = 1'b1;
        end
        checkOutput("reportDone", 64'(done), 64'd1);
        repeat (5) @(posedge clk); #1;
        checkOutput("txCount", 64'(txQ.size() - tm), 64'd8);
        got = '0;
        for (int k = 0; k < 8; k++)
            if (tm + k < txQ.size()) got = {got[55:0], txQ[tm+k]};
        checkOutput("report", got, {res, modelCnt[31:0]});
        checkOutput("enCycles", 64'(enTotal - en0), 64'(expEn));
        checkOutput("txProto", 64'(txViolations), 64'd0);
        checkOutput("idleAfter", 64'(state), 64'd0);
    endtask

    initial begin
        #10000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wm;
        int n;
        reset = 1'b1;
        rxData = '0;
        rxValid = 1'b0;
        cpuResult = '0;
        haltForce = 1'b0;
        autoHalt = 1'b0;
        haltAfter = 0;
        enAtArm = 0;
        busyLen = 3;
        modelCnt = 0;
        repeat (3) @(posedge clk); #1;
        checkOutput("resetOutputs",
                    64'({state, imemWe, imemAddr, imemWdata, cpuReset, cpuEnable, txStart, txData}), 64'd0);
        reset = 1'b0;

        loadWords[0] = 32'h2001_0005;
        loadWords[1] = 32'hAC01_0000;
        doLoad(2);
        doCmd(8'h52, 1'b0, 1'b1, 7, 32'h0000_000A, 1'b0);

        doLoad(2);
        doCmd(8'h53, 1'b0, 1'b0, 0, $urandom, 1'b0);
        doCmd(8'h53, 1'b0, 1'b0, 0, $urandom, 1'b0);
        doCmd(8'h52, 1'b1, 1'b0, 0, $urandom, 1'b0);

        busyLen = 20;
        doCmd(8'h52, 1'b1, 1'b0, 0, $urandom, 1'b1);

        busyLen = 2;
        doLoad(0);

        for (int it = 0; it < 10; it++) begin
            busyLen = $urandom_range(0, 5);
            case ($urandom_range(0, 3))
                0: begin
                    n = $urandom_range(1, 4);
                    for (int i = 0; i < n; i++) loadWords[i] = $urandom;
                    doLoad(n);
                end
                1: doCmd(8'h52, 1'b0, 1'b1, $urandom_range(0, 12), $urandom, 1'b0);
                2: doCmd(8'h53, 1'b0, 1'b0, 0, $urandom, 1'b0);
                default: doCmd(($urandom_range(0, 1) != 0) ? 8'h52 : 8'h53, 1'b1, 1'b0, 0, $urandom, 1'b0);
            endcase
        end

        doCmd(8'h53, 1'b0, 1'b0, 0, $urandom, 1'b0);
        wm = wrQ.size();
        applyStimulus(8'h4C);
        applyStimulus(8'h02);
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("midLoadReset",
                    64'({state, imemWe, imemAddr, imemWdata, cpuReset, cpuEnable, txStart, txData}), 64'd0);
        reset = 1'b0;
        modelCnt = 0;
        applyStimulus(8'h56);
        applyStimulus(8'h78);
        repeat (4) @(posedge clk); #1;
        checkOutput("midLoadNoWr", 64'(wrQ.size() - wm), 64'd0);
        checkOutput("midLoadState", 64'(state), 64'd0);
        doCmd(8'h53, 1'b1, 1'b0, 0, $urandom, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
